// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg
// Shared definitions for the HDMI output path:
//   - default 640x480@60 raster timing and the derived line/frame totals
//   - default sync polarity and PLL settle time
//   - link sequencer state encoding
//   - colour bar constants and lookup used by the optional test pattern
package hdmi_timing_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int H_FP          = 16;
  localparam int H_SYNC        = 96;
  localparam int H_BP          = 48;
  localparam int V_ACTIVE      = 480;
  localparam int V_FP          = 10;
  localparam int V_SYNC        = 2;
  localparam int V_BP          = 33;
  localparam int H_TOT         = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOT         = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
  localparam bit SYNC_POL      = 1'b0;
  localparam int SETTLE_CYCLES = 1024;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    ALIGN     = 2'd2,
    ACTIVE    = 2'd3
  } link_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bar colour, left (0) to right (7).
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// hdmi_raster_counter
// Horizontal/vertical raster counters with sync and data-enable decode.
// Optional feature macro: HDMI_TEST_PATTERN_EN (adds test_rgb_o colour bars).
// Ports:
//   clk_25mhz, reset   pixel clock, synchronous active-high reset
//   run_i              advance the counters this cycle
//   clear_i            force counters and registered outputs to idle next cycle
//   active_i           video is being emitted (gates pixel_rd_o)
//   pixel_rd_o         combinational pixel request, one cycle ahead of de_o
//   de_o/hsync_o/vsync_o/x_o/y_o  registered timing, mutually aligned
//   frame_start_o      de_o at pixel (0,0)
//   wrap_o             counters are at the last position of the frame
//   test_rgb_o         (optional) colour bars aligned with de_o
module hdmi_raster_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        run_i,
  input  logic        clear_i,
  input  logic        active_i,
  output logic        pixel_rd_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        frame_start_o,
  output logic        wrap_o
`ifdef HDMI_TEST_PATTERN_EN
  ,
  output logic [23:0] test_rgb_o
`endif
);
  import hdmi_timing_pkg::*;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  assign pixel_rd_o = active_i && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign wrap_o     = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clear_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (run_i) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
    // clear_i also kills the registered outputs so an aborted frame
    // never shows de or sync one cycle after the abort.
    de_d = !clear_i && pixel_rd_o;
    hs_d = (!clear_i && hcnt_q >= HS_BEG && hcnt_q < HS_END) ? SYNC_POL : !SYNC_POL;
    vs_d = (!clear_i && vcnt_q >= VS_BEG && vcnt_q < VS_END) ? SYNC_POL : !SYNC_POL;
    x_d  = clear_i ? 10'd0 : hcnt_q;
    y_d  = clear_i ? 10'd0 : vcnt_q;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      de_q   <= 1'b0;
      hs_q   <= !SYNC_POL;
      vs_q   <= !SYNC_POL;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = de_q && (x_q == 10'd0) && (y_q == 10'd0);

`ifdef HDMI_TEST_PATTERN_EN
  logic [2:0]  bar_idx;
  logic [23:0] rgb_q, rgb_d;

  // Eight equal-width bars; the index is the number of bar boundaries passed.
  always_comb begin
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (hcnt_q >= 10'(b * (H_ACTIVE / 8))) bar_idx = 3'(b);
    end
    rgb_d = de_d ? bar_colour(bar_idx) : 24'h000000;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign test_rgb_o = rgb_q;
`endif

endmodule

// File: rtl/hdmi_link_ctrl.sv
// hdmi_link_ctrl
// HDMI link bring-up sequencer and 640x480@60 video timing scheduler.
// Optional feature macro: HDMI_TEST_PATTERN_EN (adds test_rgb colour bars).
// Ports:
//   clk_25mhz, reset   pixel clock, synchronous active-high reset
//   pll_locked         asynchronous PLL lock, double-flop synchronised here
//   enable             software link enable (level)
//   link_rst           TMDS encoder/serialiser reset, active-high
//   pixel_rd           pixel request, one cycle ahead of de
//   de/hsync/vsync/x/y registered raster timing
//   frame_start        pulse with pixel (0,0) on de
//   link_up            high while video is being emitted
//   dbg_state          current sequencer state (link_state_e encoding)
//   test_rgb           (optional) colour bars aligned with de
// Handshake: pixel_rd is a request with no back-pressure; the source must
// present the pixel on the cycle after pixel_rd, when de is high.
module hdmi_link_ctrl #(
  parameter int H_ACTIVE      = hdmi_timing_pkg::H_ACTIVE,
  parameter int H_FP          = hdmi_timing_pkg::H_FP,
  parameter int H_SYNC        = hdmi_timing_pkg::H_SYNC,
  parameter int H_BP          = hdmi_timing_pkg::H_BP,
  parameter int V_ACTIVE      = hdmi_timing_pkg::V_ACTIVE,
  parameter int V_FP          = hdmi_timing_pkg::V_FP,
  parameter int V_SYNC        = hdmi_timing_pkg::V_SYNC,
  parameter int V_BP          = hdmi_timing_pkg::V_BP,
  parameter bit SYNC_POL      = hdmi_timing_pkg::SYNC_POL,
  parameter int SETTLE_CYCLES = hdmi_timing_pkg::SETTLE_CYCLES
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        pll_locked,
  input  logic        enable,
  output logic        link_rst,
  output logic        pixel_rd,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        link_up,
  output logic [1:0]  dbg_state
`ifdef HDMI_TEST_PATTERN_EN
  ,
  output logic [23:0] test_rgb
`endif
);
  import hdmi_timing_pkg::*;

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                lock_meta_q, lock_sync_q;
  link_state_e         state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                run, clear, active, wrap;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Lock loss always wins and is immediate. Every other exit from video
  // happens only on the frame wrap, so enable is simply sampled there:
  // re-asserting it before the wrap cancels the drain.
  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    unique case (state_q)
      WAIT_LOCK: if (lock_sync_q && enable) state_d = SETTLE;
      SETTLE: begin
        if (!lock_sync_q)               state_d = WAIT_LOCK;
        else if (settle_q == SETTLE_LAST) state_d = ALIGN;
        else                            settle_d = settle_q + 1'b1;
      end
      ALIGN: begin
        if (!lock_sync_q) state_d = WAIT_LOCK;
        else if (wrap)    state_d = enable ? ACTIVE : WAIT_LOCK;
      end
      ACTIVE: begin
        if (!lock_sync_q)        state_d = WAIT_LOCK;
        else if (wrap && !enable) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    link_rst = 1'b1;
    link_up  = 1'b0;
    run      = 1'b0;
    active   = 1'b0;
    unique case (state_q)
      ALIGN: begin
        link_rst = 1'b0;
        run      = 1'b1;
      end
      ACTIVE: begin
        link_rst = 1'b0;
        run      = 1'b1;
        active   = 1'b1;
        link_up  = 1'b1;
      end
      default: ;
    endcase
    // Clearing on the next state lets an abort zero the raster in the same edge.
    clear = (state_d == WAIT_LOCK) || (state_d == SETTLE);
  end

  assign dbg_state = state_q;

  hdmi_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_raster (
    .clk_25mhz     (clk_25mhz),
    .reset         (reset),
    .run_i         (run),
    .clear_i       (clear),
    .active_i      (active),
    .pixel_rd_o    (pixel_rd),
    .de_o          (de),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .x_o           (x),
    .y_o           (y),
    .frame_start_o (frame_start),
    .wrap_o        (wrap)
`ifdef HDMI_TEST_PATTERN_EN
    ,
    .test_rgb_o    (test_rgb)
`endif
  );

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// tb_hdmi_link_ctrl
// Bench for hdmi_link_ctrl with a scaled-down raster so several frames fit
// in a short run. A timestamp-based reference model predicts every output
// every cycle; directed measurements cover latencies and frame counts.
module tb_hdmi_link_ctrl;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int SC = 20;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [26:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  // ---------------- clock / reset ----------------
  logic clk_25mhz = 1'b0;
  logic reset = 1'b1, pll_locked = 1'b0, enable = 1'b0;
  logic link_rst, pixel_rd, de, hsync, vsync, frame_start, link_up;
  logic [9:0] x, y;
  logic [1:0] dbg_state;
`ifdef HDMI_TEST_PATTERN_EN
  logic [23:0] test_rgb;
`endif

  always #20 clk_25mhz = ~clk_25mhz;

  hdmi_link_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .pll_locked(pll_locked), .enable(enable),
    .link_rst(link_rst), .pixel_rd(pixel_rd), .de(de), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .frame_start(frame_start), .link_up(link_up), .dbg_state(dbg_state)
`ifdef HDMI_TEST_PATTERN_EN
    , .test_rgb(test_rgb)
`endif
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] dut_vec();
    return {link_rst, link_up, pixel_rd, de, hsync, vsync, frame_start, x, y};
  endfunction

  // ---------------- reference model ----------------
  // Phases: link off, lock settling, aligning to a frame, emitting video.
  // Raster position is derived from the cycle the alignment began.
  localparam int M_OFF = 0, M_SETTLING = 1, M_ALIGNING = 2, M_VIDEO = 3;
  int m_ph = M_OFF, m_cyc = 0, m_t0 = 0;
  bit m_lk1 = 0, m_lk2 = 0;
  bit e_de = 0, e_hs = 1, e_vs = 1;
  int e_x = 0, e_y = 0;
  logic [23:0] e_rgb = '0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [26:0] exp_q[$];
  logic [23:0] exp_rgb_q[$];

  function automatic int m_pos();
    return (m_ph >= M_ALIGNING) ? (m_cyc - m_t0) % FRAME : 0;
  endfunction

  task automatic model_step();
    int pos, h, v, ph_new;
    bit rd_old, run_new;
    if (reset) begin
      m_ph = M_OFF; m_lk1 = 0; m_lk2 = 0;
      e_de = 0; e_hs = 1; e_vs = 1; e_x = 0; e_y = 0; e_rgb = '0;
      m_cyc++;
      return;
    end
    pos = m_pos(); h = pos % HT; v = pos / HT;
    rd_old = (m_ph == M_VIDEO) && h < HA && v < VA;
    ph_new = m_ph;
    case (m_ph)
      M_OFF: if (m_lk2 && enable) begin ph_new = M_SETTLING; m_t0 = m_cyc + 1; end
      M_SETTLING: begin
        if (!m_lk2) ph_new = M_OFF;
        else if (m_cyc + 1 - m_t0 == SC) begin ph_new = M_ALIGNING; m_t0 = m_cyc + 1; end
      end
      default: begin
        if (!m_lk2) ph_new = M_OFF;
        else if (pos == FRAME - 1) ph_new = enable ? M_VIDEO : M_OFF;
      end
    endcase
    run_new = ph_new >= M_ALIGNING;
    e_de = run_new && rd_old;
    e_hs = !(run_new && h >= HA + HFP && h < HA + HFP + HS);
    e_vs = !(run_new && v >= VA + VFP && v < VA + VFP + VS);
    e_x = run_new ? h : 0;
    e_y = run_new ? v : 0;
    e_rgb = e_de ? bars[h / (HA / 8)] : 24'h0;
    m_lk2 = m_lk1; m_lk1 = pll_locked;
    m_ph = ph_new;
    m_cyc++;
  endtask

  function automatic logic [26:0] model_vec();
    int pos, h, v;
    bit rd;
    pos = m_pos(); h = pos % HT; v = pos / HT;
    rd = (m_ph == M_VIDEO) && h < HA && v < VA;
    return {m_ph <= M_SETTLING, m_ph == M_VIDEO, rd, e_de, e_hs, e_vs,
            e_de && e_x == 0 && e_y == 0, 10'(e_x), 10'(e_y)};
  endfunction

  always @(posedge clk_25mhz) begin
    model_step();
    exp_q.push_back(model_vec());
    exp_rgb_q.push_back(e_rgb);
  end

  // ---------------- scoreboard ----------------
  logic [26:0] sb_exp;
  logic [23:0] sb_rgb;
  always @(negedge clk_25mhz) begin
    if (exp_q.size() == 0) check("exp_q_empty", 32'(exp_q.size()), 32'd1);
    else begin
      sb_exp = exp_q.pop_front();
      check("cycle_outputs", 32'(dut_vec()), 32'(sb_exp));
    end
    if (exp_rgb_q.size() != 0) begin
      sb_rgb = exp_rgb_q.pop_front();
`ifdef HDMI_TEST_PATTERN_EN
      check("test_rgb", 32'(test_rgb), 32'(sb_rgb));
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic wait_line(input int line, input string tag);
    int n = 0;
    while (!(link_up && y == 10'(line)) && n < 4 * FRAME) begin cycles(1); n++; end
    check(tag, 32'(n < 4 * FRAME), 32'd1);
  endtask

  task automatic wait_link_up(input string tag);
    int n = 0;
    while (!link_up && n < 4 * FRAME + 4 * SC) begin cycles(1); n++; end
    check(tag, 32'(link_up), 32'd1);
  endtask

  int n, cnt, de_cnt, hs_cnt, vs_cnt, lead_err, drops, xx;
  bit rd_prev;

  initial begin
    cycles(3);
    check("reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
    reset = 1'b0;

    // Bring-up: link_rst falls 2 sync + SC settle + 1 cycles after lock.
    pll_locked = 1'b1; enable = 1'b1;
    n = 0;
    while (link_rst && n < 200) begin cycles(1); n++; end
    check("link_rst_lat", 32'(n), 32'(2 + SC + 1));
    n = 0;
    while (!pixel_rd && n < 2 * FRAME) begin cycles(1); n++; end
    check("first_rd_lat", 32'(n), 32'(FRAME));
    cycles(1);
    check("first_de_fs", 32'({de, frame_start, x, y}), 32'({1'b1, 1'b1, 20'd0}));

    // Steady-state frame statistics.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; lead_err = 0; rd_prev = pixel_rd;
    for (int i = 0; i < FRAME; i++) begin
      de_cnt += de; hs_cnt += !hsync; vs_cnt += !vsync;
      cycles(1);
      if (de !== rd_prev) lead_err++;
      rd_prev = pixel_rd;
    end
    check("de_per_frame", 32'(de_cnt), 32'(HA * VA));
    check("hsync_low_per_frame", 32'(hs_cnt), 32'(HS * VT));
    check("vsync_low_per_frame", 32'(vs_cnt), 32'(VS * HT));
    check("rd_leads_de", 32'(lead_err), 32'd0);

    // Lock loss mid-frame: de drops, link_rst rises one cycle after sync'd drop.
    wait_line(2, "wait_line2");
    pll_locked = 1'b0;
    n = 0;
    while (!link_rst && n < 20) begin cycles(1); n++; end
    check("lock_loss_lat", 32'(n), 32'd3);
    check("lock_loss_de", 32'(de), 32'd0);
    cycles(5 - n);
    pll_locked = 1'b1;
    wait_link_up("relock_up");

    // Enable dropped then restored before the wrap: no drop.
    wait_line(3, "wait_drain_a");
    enable = 1'b0;
    wait_line(6, "wait_drain_b");
    enable = 1'b1;
    drops = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin cycles(1); drops += !link_up; end
    check("drain_cancel", 32'(drops), 32'd0);

    // Enable dropped for good: frame completes then link_up falls at the wrap.
    wait_line(3, "wait_drain_c");
    xx = x;
    enable = 1'b0;
    n = 0;
    while (link_up && n < 2 * FRAME) begin cycles(1); n++; end
    check("drain_len", 32'(n), 32'(FRAME - (3 * HT + xx + 1)));

    // Lock glitch while settling restarts the settle count.
    enable = 1'b1;
    cycles(8);
    check("settling_rst", 32'(link_rst), 32'd1);
    pll_locked = 1'b0;
    cycles(1);
    pll_locked = 1'b1;
    n = 0;
    while (link_rst && n < 200) begin cycles(1); n++; end
    check("settle_restart", 32'(n), 32'(2 + SC + 1));

    // Reset in the middle of a frame.
    wait_link_up("pre_reset_up");
    wait_line(3, "wait_reset_line");
    reset = 1'b1;
    cycles(1);
    check("midframe_reset", 32'(dut_vec()), 32'(RESET_VEC));
    reset = 1'b0;

    // Randomised lock glitches, enable toggles and resets.
    for (int it = 0; it < 30; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 4) begin
        pll_locked = 1'b1; enable = 1'b1;
        cycles($urandom_range(50, 2 * FRAME));
      end else if (act < 7) begin
        cycles($urandom_range(0, FRAME));
        pll_locked = 1'b0;
        cycles($urandom_range(1, 6));
        pll_locked = 1'b1;
      end else if (act < 9) begin
        enable = 1'b0;
        cycles($urandom_range(1, FRAME));
        enable = 1'b1;
      end else begin
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
      end
    end
    cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
